// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch -- single-outstanding-read fetch unit with a one-entry
// skid buffer, redirect support and zero-word halt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ADDR_SPAN = 32'(4 * MEM_WORDS);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic        resp_v_q;
  logic [31:0] resp_pc_q;
  logic        skid_v_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] fetch_count_q;

  logic        run;
  logic        accept;
  logic        issue;
  logic [31:0] fetch_pc_d;
  logic [31:0] redirect_pc_d;

  always_comb begin
    run           = (state_q == RUN);
    valid         = (skid_v_q || resp_v_q) && !redirect && run;
    instr         = 32'h0;
    instr_pc      = 32'h0;
    if (valid) begin
      instr    = skid_v_q ? skid_instr_q : imem_data;
      instr_pc = skid_v_q ? skid_pc_q    : resp_pc_q;
    end
    accept        = valid && ready;
    issue         = run && !redirect && !reset && (!valid || ready);
    fetch_pc_d    = (fetch_pc_q >= ADDR_SPAN - 32'd4) ? 32'h0 : fetch_pc_q + 32'd4;
    redirect_pc_d = (redirect_pc & ~32'h3) % ADDR_SPAN;
  end

  assign imem_addr   = fetch_pc_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      resp_v_q      <= 1'b0;
      resp_pc_q     <= 32'h0;
      skid_v_q      <= 1'b0;
      skid_instr_q  <= 32'h0;
      skid_pc_q     <= 32'h0;
      fetch_count_q <= 32'h0;
    end else if (state_q == RUN) begin
      if (redirect) begin
        // A redirect squashes everything in flight, including a zero-word accept.
        fetch_pc_q <= redirect_pc_d;
        resp_v_q   <= 1'b0;
        skid_v_q   <= 1'b0;
      end else begin
        resp_v_q <= issue;
        if (issue) begin
          resp_pc_q  <= fetch_pc_q;
          fetch_pc_q <= fetch_pc_d;
        end
        if (accept) begin
          fetch_count_q <= fetch_count_q + 32'd1;
        end
        if (accept && (instr == 32'h0)) begin
          state_q  <= HALT;
          resp_v_q <= 1'b0;
          skid_v_q <= 1'b0;
        end else if (valid && !ready && resp_v_q && !skid_v_q) begin
          // Stalled response would be lost next cycle; park it in the skid entry.
          skid_v_q     <= 1'b1;
          skid_instr_q <= imem_data;
          skid_pc_q    <= resp_pc_q;
        end else if (accept && skid_v_q) begin
          skid_v_q <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus randomized traffic,
// all checked against a stream-level model of the delivered instruction sequence.
`default_nettype none

module tb_instruction_fetch;

  localparam int          MW   = 32;
  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] SPAN = 32'(4 * MW);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic [31:0] fetch_count;

  always #5 clock = ~clock;

  instruction_fetch #(.RESET_PC(RPC), .MEM_WORDS(MW)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .ready(ready), .valid(valid),
    .instr(instr), .instr_pc(instr_pc), .halted(halted), .fetch_count(fetch_count)
  );

  logic [31:0] mem [MW];

  function automatic int widx(input logic [31:0] pc);
    return int'((pc % SPAN) / 32'd4);
  endfunction

  always @(posedge clock) imem_data <= mem[widx(imem_addr)];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Model: the next PC decode should see, whether a word is ready to show,
  // run/halt status and the accept count.
  bit          m_run  = 1'b1;
  bit          m_have = 1'b0;
  logic [31:0] m_pc   = RPC;
  logic [31:0] m_count = 32'h0;

  task automatic step(input bit rst, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          ev;
    logic [31:0] ew;
    @(negedge clock);
    reset = rst; ready = rdy; redirect = redir; redirect_pc = rpc;
    #1;
    ev = m_run && m_have && !redir;
    ew = mem[widx(m_pc)];
    check("valid",       {31'b0, valid},  {31'b0, ev});
    check("instr",       instr,           ev ? ew : 32'h0);
    check("instr_pc",    instr_pc,        ev ? m_pc : 32'h0);
    check("halted",      {31'b0, halted}, {31'b0, !m_run});
    check("fetch_count", fetch_count,     m_count);
    if (rst) begin
      m_run = 1'b1; m_have = 1'b0; m_pc = RPC; m_count = 32'h0;
    end else if (m_run) begin
      if (redir) begin
        m_have = 1'b0;
        m_pc   = ((rpc % SPAN) >> 2) << 2;
      end else begin
        m_have = 1'b1;
        if (ev && rdy) begin
          m_count = m_count + 32'd1;
          m_pc    = (m_pc + 32'd4) % SPAN;
          if (ew == 32'h0) m_run = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clock); #1;
    check("imem_addr_rst", imem_addr, RPC);
  endtask

  task automatic load_prog_a();
    for (int i = 0; i < MW; i++) mem[i] = (i < 8) ? 32'h001080B3 : ((i == 8) ? 32'h0 : 32'h00000013 + 32'(i));
  endtask

  initial begin
    int hold;
    load_prog_a();
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Straight-line run into a halt.
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clock); #1;
    check("halted_run", {31'b0, halted}, 32'd1);
    check("count_run",  fetch_count,     32'd9);

    // Backpressure while 0x08 is presented.
    do_reset();
    hold = 0;
    for (int i = 0; i < 16; i++) begin
      bit r;
      r = !(m_run && m_have && m_pc == 32'h8 && hold < 3);
      if (!r) hold++;
      step(1'b0, r, 1'b0, 32'h0);
    end
    check("stall_count", 32'(hold), 32'd3);

    // Redirect to an unaligned target while 0x04 is valid.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (m_have && m_pc == 32'h4) begin
        step(1'b0, 1'b1, 1'b1, 32'h16);
        break;
      end
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    @(posedge clock); #1;
    check("count_redir", fetch_count, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with the zero-word accept.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (m_have && m_pc == 32'h20) begin
        step(1'b0, 1'b1, 1'b1, 32'h0);
        break;
      end
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    @(posedge clock); #1;
    check("halted_prio", {31'b0, halted}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // No zero word: PC wraps 0x7C -> 0x00.
    for (int i = 0; i < MW; i++) mem[i] = 32'h1000_0000 + 32'(i);
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_pc", m_pc, 32'h1C);

    // Reset with the skid buffer occupied, then reset out of HALT.
    load_prog_a();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clock); #1;
    check("rst_skid_valid", {31'b0, valid}, 32'd0);
    check("rst_skid_count", fetch_count,    32'd0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1 && (i == 12), 32'h40);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clock); #1;
    check("rst_halt_halted", {31'b0, halted}, 32'd0);
    check("rst_halt_count",  fetch_count,     32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < MW; i++) mem[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
    for (int i = 0; i < 4000; i++) begin
      bit rs, rd, rr;
      rs = ($urandom_range(0, 99) == 0);
      rr = ($urandom_range(0, 11) == 0);
      rd = ($urandom_range(0, 9) < 7);
      step(rs, rd, rr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
